// File: rtl/cpu_clk_reset_gen.sv
// cpu_clk_reset_gen: 65C02 phi2 clock divider and debounced CPU reset sequencer.
//
// Ports:
//   clk_50       in  fabric clock; all state updates on its rising edge
//   rst_n        in  asynchronous active-low reset
//   button_reset in  raw board button, active-low, asynchronous to clk_50
//   cpu_phi2     out registered CPU clock, 50% duty, period 2*DIV_HALF cycles
//   cpu_resb     out registered CPU reset, active-low
//   phi2_rise    out one-cycle strobe in the first clk_50 cycle with cpu_phi2 high
//   phi2_fall    out one-cycle strobe in the first clk_50 cycle with cpu_phi2 low
module cpu_clk_reset_gen #(
    parameter int DIV_HALF          = 12,
    parameter int DEBOUNCE_CYCLES   = 65536,
    parameter int RESET_PHI2_CYCLES = 8
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic button_reset,
    output logic cpu_phi2,
    output logic cpu_resb,
    output logic phi2_rise,
    output logic phi2_fall
);
    localparam int DW = $clog2(DIV_HALF);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(RESET_PHI2_CYCLES);
    localparam logic [DW-1:0] DIV_MAX  = DW'(DIV_HALF - 1);
    localparam logic [BW-1:0] DB_MAX   = BW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_PHI2_CYCLES - 1);

    typedef enum logic {HOLD, RUN} state_t;

    logic [DW-1:0] div_q, div_d;
    logic          phi2_q, phi2_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [1:0]    sync_q, sync_d;
    logic [BW-1:0] db_cnt_q, db_cnt_d;
    logic          btn_db_q, btn_db_d;
    logic [HW-1:0] hold_q, hold_d;
    state_t        state_q, state_d;
    logic          resb_q, resb_d;
    logic          wrap, differ, db_done, btn_ok;

    always_comb begin
        wrap     = div_q == DIV_MAX;
        div_d    = wrap ? '0 : div_q + DW'(1);
        phi2_d   = phi2_q ^ wrap;
        rise_d   = wrap & ~phi2_q;
        fall_d   = wrap & phi2_q;
        sync_d   = {sync_q[0], button_reset};
        differ   = sync_q[1] != btn_db_q;
        db_done  = differ && db_cnt_q == DB_MAX;
        db_cnt_d = (differ && !db_done) ? db_cnt_q + BW'(1) : '0;
        btn_db_d = db_done ? sync_q[1] : btn_db_q;
        // Counting needs the button released both now and after this edge, so a
        // release coinciding with a fall is not counted and a press coinciding
        // with the final fall keeps the CPU in reset.
        btn_ok   = btn_db_q & btn_db_d;
        state_d  = state_q;
        hold_d   = hold_q;
        unique case (state_q)
            HOLD: begin
                if (!btn_ok) begin
                    hold_d = '0;
                end else if (fall_d) begin
                    state_d = hold_q == HOLD_MAX ? RUN : HOLD;
                    hold_d  = hold_q == HOLD_MAX ? '0 : hold_q + HW'(1);
                end
            end
            RUN: begin
                if (!btn_db_q) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = HOLD;
                hold_d  = '0;
            end
        endcase
        resb_d = state_d == RUN;
    end

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            phi2_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            sync_q   <= 2'b11;
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
            hold_q   <= '0;
            state_q  <= HOLD;
            resb_q   <= 1'b0;
        end else begin
            div_q    <= div_d;
            phi2_q   <= phi2_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
            hold_q   <= hold_d;
            state_q  <= state_d;
            resb_q   <= resb_d;
        end
    end

    assign cpu_phi2  = phi2_q;
    assign cpu_resb  = resb_q;
    assign phi2_rise = rise_q;
    assign phi2_fall = fall_q;
endmodule
